fifo_mshr_pool: RTL and testbench
=================================

FIFO_MSHR_POOL -- requirements
Module: fifo_mshr_pool

Interface
REQ-001 Parameter NUM_MSHR, default 4: number of load-tracking entries; power of two, 2..16.
REQ-002 Parameter CHECKPOINT_INTERVAL, default 32: data transactions between checkpoints; power of two, ≥2.
REQ-003 Parameter MSHRID_BASE, default 8'd144: mshrid of entry 0; entry i uses MSHRID_BASE+i.
REQ-004 Ports, in order (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rst_n, in, 1, reset; asynchronous, active-low.
- addr_valid_i, in, 1, address-generator request valid.
- addr_i, in, 64, load address.
- size_i, in, 32, load size code.
- addr_ready_o, out, 1, a free entry exists.
- fifo_length_i, in, 32, FIFO depth in elements; quasi-static, ≥1.
- ld_req_valid_o, out, 1, load request valid.
- ld_req_addr_o, out, 64, load address.
- ld_req_size_o, out, 32, load size.
- ld_req_mshrid_o, out, 8, entry tag.
- ld_req_ready_i, in, 1, memory accepts the request.
- ld_resp_valid_i, in, 1, response valid; always accepted.
- ld_resp_mshrid_i, in, 8, response tag.
- ld_resp_data_i, in, 64, response data.
- trans_valid_o, out, 1, transaction valid.
- trans_data_o, out, 64, transaction payload.
- trans_addr_o, out, 64, load address, or tail_ptr_addr_i for a checkpoint.
- trans_ckpt_o, out, 1, the transaction is a checkpoint.
- trans_ready_i, in, 1, consumer accepts the transaction.
- tail_ptr_addr_i, in, 64, checkpoint store address.
- tail_ptr_o, out, 32, current tail pointer.

Function
REQ-005 Entry states: FREE, SEND, WAIT, DONE.
REQ-006 Allocation, issue and commit each use a ring pointer of $clog2(NUM_MSHR) bits; each pointer advances by one per event and wraps NUM_MSHR-1 to 0.
REQ-007 addr_ready_o=1 iff the entry at the allocation pointer is FREE.
REQ-008 On addr_valid_i && addr_ready_o: that entry captures addr_i and size_i and goes FREE->SEND.
REQ-009 ld_req_valid_o=1 iff the entry at the issue pointer is SEND; ld_req_* carry that entry's fields.
REQ-010 ld_req_* are held stable while ld_req_valid_o && !ld_req_ready_i.
REQ-011 On handshake: entry goes SEND->WAIT; at most one issue per cycle; issue order equals allocation order.
REQ-012 A response whose tag matches an entry in WAIT captures the data and moves that entry to DONE. Responses may return in any order.
REQ-013 Responses matching no WAIT entry are dropped without state change.
REQ-014 Commit is in order, from the commit pointer only.
REQ-015 trans_valid_o=1 when a checkpoint is pending, or when the head entry is DONE.
REQ-016 Data transaction: trans_data_o=entry data, trans_addr_o=entry address, trans_ckpt_o=0. On handshake the entry goes DONE->FREE and the tail pointer advances.
REQ-017 The tail pointer wraps to 0 when equal to fifo_length_i-1, else increments; it changes only on data-transaction handshakes.
REQ-018 A $clog2(CHECKPOINT_INTERVAL)-bit counter increments on each data handshake. When it wraps to 0, a checkpoint becomes pending.
REQ-019 A pending checkpoint takes priority over the next data transaction. Fields: trans_data_o = zero-extended post-increment tail pointer, trans_addr_o=tail_ptr_addr_i, trans_ckpt_o=1.
REQ-020 A checkpoint's handshake clears pending and does not move the tail pointer or counter.
REQ-021 trans_* are held stable while valid and not ready.
REQ-022 Allocation and issue may free-run while a checkpoint is pending.
REQ-023 Minimum latency: request handshake in cycle t, response in cycle t+1, trans_valid_o in cycle t+2.
REQ-024 A response captured in cycle t is not committed before t+1.
REQ-025 Same-cycle events on distinct entries (allocate, issue, respond, commit) all take effect.
REQ-026 With NUM_MSHR entries outstanding, addr_ready_o=0 until a commit frees the head entry. The freed entry is allocatable in the following cycle.

Reset
REQ-027 While rst_n=0, all entries are FREE, all pointers and the counter are 0, tail pointer=0, and no checkpoint is pending.
REQ-028 During reset, outputs are: addr_ready_o=1, ld_req_valid_o=0, trans_valid_o=0, trans_ckpt_o=0, tail_ptr_o=0, and data/address outputs 0.
REQ-029 Reset mid-operation discards all in-flight entries. The memory side shall be quiesced before reset is released, since stale responses can match new WAIT entries.

Structure
REQ-030 fifo_ctrl_pkg holds: the entry-state enum, the entry struct (addr, size, data), the 64-bit address/data widths, and the 32-bit size and length types.
REQ-031 A sub-module fifo_mshr_entry holds one entry's state and fields; it is instantiated NUM_MSHR times through generate.

Verification
REQ-032 Single load: addr 0x1000, response tag 144 with data 0xA5 one cycle after issue -> transaction data 0xA5, addr 0x1000, ckpt 0, tail_ptr_o=1.
REQ-033 Out-of-order responses: 4 loads issued, responses with tags 147,145,146,144 -> transactions in allocation order, first committing only after tag 144.
REQ-034 Full pool: 4 outstanding loads, addr_valid_i held -> addr_ready_o=0 until the first commit, 1 the next cycle.
REQ-035 Checkpoint: CHECKPOINT_INTERVAL=4, fifo_length_i=3, 4 loads -> after 4th data transaction a checkpoint with data 1, addr=tail_ptr_addr_i, ckpt=1; tail wrap 2->0 observed.
REQ-036 Backpressure and noise: trans_ready_i and ld_req_ready_i low 5 cycles, unmatched tag 200 injected -> outputs stable, no state change; rst_n asserted mid-flight -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared types for the FIFO load-tracking pool: entry state, entry fields and
// the tail-pointer wrap rule.
package fifo_ctrl_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [31:0]       size_t;
  typedef logic [31:0]       len_t;

  typedef enum logic [1:0] {
    ST_FREE,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } entry_state_e;

  typedef struct packed {
    addr_t addr;
    size_t size;
    data_t data;
  } entry_t;

  // The tail wraps after the last FIFO slot rather than at a power of two.
  function automatic len_t next_tail(input len_t tail, input len_t length);
    return (tail == length - 32'd1) ? '0 : tail + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_mshr_entry.sv
// One load-tracking entry: walks FREE -> SEND -> WAIT -> DONE -> FREE and keeps
// the captured address, size and response data.
module fifo_mshr_entry
  import fifo_ctrl_pkg::*;
#(
  parameter logic [7:0] MSHRID = 8'd0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         alloc,
  input  addr_t        addr,
  input  size_t        size,
  input  logic         issue,
  input  logic         resp_valid,
  input  logic [7:0]   resp_mshrid,
  input  data_t        resp_data,
  input  logic         commit,
  output entry_state_e state,
  output entry_t       fields
);

  // Each event is only honoured in the state that expects it, so a stale or
  // duplicate response never disturbs an entry that is not waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_FREE;
      fields <= '0;
    end else begin
      case (state)
        ST_FREE: if (alloc) begin
          state       <= ST_SEND;
          fields.addr <= addr;
          fields.size <= size;
          fields.data <= '0;
        end
        ST_SEND: if (issue) state <= ST_WAIT;
        ST_WAIT: if (resp_valid && resp_mshrid == MSHRID) begin
          state       <= ST_DONE;
          fields.data <= resp_data;
        end
        ST_DONE: if (commit) state <= ST_FREE;
        default: state <= ST_FREE;
      endcase
    end
  end

endmodule

// File: rtl/fifo_mshr_pool.sv
// Pool of load-tracking entries feeding an in-order transaction stream with
// periodic tail-pointer checkpoints.
module fifo_mshr_pool
  import fifo_ctrl_pkg::*;
#(
  parameter int         NUM_MSHR            = 4,
  parameter int         CHECKPOINT_INTERVAL = 32,
  parameter logic [7:0] MSHRID_BASE         = 8'd144
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        addr_valid_i,
  input  logic [63:0] addr_i,
  input  logic [31:0] size_i,
  output logic        addr_ready_o,
  input  logic [31:0] fifo_length_i,
  output logic        ld_req_valid_o,
  output logic [63:0] ld_req_addr_o,
  output logic [31:0] ld_req_size_o,
  output logic [7:0]  ld_req_mshrid_o,
  input  logic        ld_req_ready_i,
  input  logic        ld_resp_valid_i,
  input  logic [7:0]  ld_resp_mshrid_i,
  input  logic [63:0] ld_resp_data_i,
  output logic        trans_valid_o,
  output logic [63:0] trans_data_o,
  output logic [63:0] trans_addr_o,
  output logic        trans_ckpt_o,
  input  logic        trans_ready_i,
  input  logic [63:0] tail_ptr_addr_i,
  output logic [31:0] tail_ptr_o
);

  localparam int PW = $clog2(NUM_MSHR);
  localparam int CW = $clog2(CHECKPOINT_INTERVAL);

  logic [PW-1:0] alloc_ptr, issue_ptr, commit_ptr;
  logic [CW-1:0] ckpt_cnt;
  logic          ckpt_pending;
  len_t          tail_ptr;

  entry_state_e  st  [NUM_MSHR];
  entry_t        fld [NUM_MSHR];

  logic addr_fire, issue_fire, head_done, data_fire, ckpt_fire;

  assign addr_ready_o = (st[alloc_ptr] == ST_FREE);
  assign addr_fire    = addr_valid_i && addr_ready_o;

  assign ld_req_valid_o  = (st[issue_ptr] == ST_SEND);
  assign issue_fire      = ld_req_valid_o && ld_req_ready_i;
  assign ld_req_addr_o   = ld_req_valid_o ? fld[issue_ptr].addr : '0;
  assign ld_req_size_o   = ld_req_valid_o ? fld[issue_ptr].size : '0;
  assign ld_req_mshrid_o = ld_req_valid_o ? MSHRID_BASE + 8'(issue_ptr) : '0;

  // A pending checkpoint masks the head entry so it cannot slip past it.
  assign head_done     = (st[commit_ptr] == ST_DONE);
  assign trans_valid_o = ckpt_pending || head_done;
  assign trans_ckpt_o  = ckpt_pending;
  assign data_fire     = !ckpt_pending && head_done && trans_ready_i;
  assign ckpt_fire     = ckpt_pending && trans_ready_i;
  assign trans_data_o  = ckpt_pending ? {32'b0, tail_ptr}
                       : (head_done ? fld[commit_ptr].data : '0);
  assign trans_addr_o  = ckpt_pending ? tail_ptr_addr_i
                       : (head_done ? fld[commit_ptr].addr : '0);
  assign tail_ptr_o    = tail_ptr;

  for (genvar i = 0; i < NUM_MSHR; i++) begin : g_entry
    localparam logic [7:0] ID = MSHRID_BASE + 8'(i);
    fifo_mshr_entry #(.MSHRID(ID)) u_entry (
      .clk         (clk),
      .rst_n       (rst_n),
      .alloc       (addr_fire && alloc_ptr == PW'(i)),
      .addr        (addr_i),
      .size        (size_i),
      .issue       (issue_fire && issue_ptr == PW'(i)),
      .resp_valid  (ld_resp_valid_i),
      .resp_mshrid (ld_resp_mshrid_i),
      .resp_data   (ld_resp_data_i),
      .commit      (data_fire && commit_ptr == PW'(i)),
      .state       (st[i]),
      .fields      (fld[i])
    );
  end

  // The counter wraps on the data handshake that completes an interval,
  // which is exactly when the checkpoint becomes pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr    <= '0;
      issue_ptr    <= '0;
      commit_ptr   <= '0;
      ckpt_cnt     <= '0;
      ckpt_pending <= 1'b0;
      tail_ptr     <= '0;
    end else begin
      if (addr_fire)  alloc_ptr <= alloc_ptr + PW'(1);
      if (issue_fire) issue_ptr <= issue_ptr + PW'(1);
      if (data_fire) begin
        commit_ptr <= commit_ptr + PW'(1);
        tail_ptr   <= next_tail(tail_ptr, fifo_length_i);
        ckpt_cnt   <= ckpt_cnt + CW'(1);
        if (&ckpt_cnt) ckpt_pending <= 1'b1;
      end
      if (ckpt_fire) ckpt_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_mshr_pool.sv
// Scoreboard bench for fifo_mshr_pool: directed loads push expected requests
// and transactions; negedge monitors pop and compare on every handshake.
module tb_fifo_mshr_pool;
  import fifo_ctrl_pkg::*;

  localparam int          NUM_MSHR  = 4;
  localparam int          CKPT      = 4;
  localparam logic [7:0]  BASE      = 8'd144;
  localparam logic [63:0] TAIL_ADDR = 64'hCAFE_0000;

  logic        clk, rst_n;
  logic        addr_valid_i, addr_ready_o;
  logic [63:0] addr_i;
  logic [31:0] size_i, fifo_length_i;
  logic        ld_req_valid_o, ld_req_ready_i;
  logic [63:0] ld_req_addr_o;
  logic [31:0] ld_req_size_o;
  logic [7:0]  ld_req_mshrid_o;
  logic        ld_resp_valid_i;
  logic [7:0]  ld_resp_mshrid_i;
  logic [63:0] ld_resp_data_i;
  logic        trans_valid_o, trans_ckpt_o, trans_ready_i;
  logic [63:0] trans_data_o, trans_addr_o, tail_ptr_addr_i;
  logic [31:0] tail_ptr_o;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] size;
    logic [7:0]  tag;
  } req_t;

  typedef struct {
    logic [63:0] data;
    logic [63:0] addr;
    logic        ckpt;
  } trn_t;

  req_t        exp_req[$];
  trn_t        exp_trans[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          alloc_cnt = 0;
  logic [31:0] tail_m;
  req_t        mon_r;
  trn_t        mon_t;

  fifo_mshr_pool #(
    .NUM_MSHR(NUM_MSHR), .CHECKPOINT_INTERVAL(CKPT), .MSHRID_BASE(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .addr_valid_i(addr_valid_i), .addr_i(addr_i), .size_i(size_i),
    .addr_ready_o(addr_ready_o), .fifo_length_i(fifo_length_i),
    .ld_req_valid_o(ld_req_valid_o), .ld_req_addr_o(ld_req_addr_o),
    .ld_req_size_o(ld_req_size_o), .ld_req_mshrid_o(ld_req_mshrid_o),
    .ld_req_ready_i(ld_req_ready_i), .ld_resp_valid_i(ld_resp_valid_i),
    .ld_resp_mshrid_i(ld_resp_mshrid_i), .ld_resp_data_i(ld_resp_data_i),
    .trans_valid_o(trans_valid_o), .trans_data_o(trans_data_o),
    .trans_addr_o(trans_addr_o), .trans_ckpt_o(trans_ckpt_o),
    .trans_ready_i(trans_ready_i), .tail_ptr_addr_i(tail_ptr_addr_i),
    .tail_ptr_o(tail_ptr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: unexpected handshake with empty scoreboard", name);
  endtask

  task automatic push_req(input logic [63:0] a, input logic [31:0] s);
    req_t r;
    r.addr = a;
    r.size = s;
    r.tag  = BASE + 8'(alloc_cnt % NUM_MSHR);
    exp_req.push_back(r);
    alloc_cnt++;
  endtask

  task automatic expect_trans(input logic [63:0] d, input logic [63:0] a, input logic c);
    trn_t t;
    t.data = d;
    t.addr = a;
    t.ckpt = c;
    exp_trans.push_back(t);
  endtask

  task automatic applyStimulus(input logic [63:0] a, input logic [31:0] s);
    int budget = 0;
    addr_valid_i = 1'b1;
    addr_i = a;
    size_i = s;
    @(negedge clk);
    while (!addr_ready_o && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("alloc_ready", 64'(addr_ready_o), 64'd1);
    push_req(a, s);
    @(posedge clk); #1;
    addr_valid_i = 1'b0;
  endtask

  task automatic respond(input logic [7:0] tag, input logic [63:0] d);
    ld_resp_valid_i  = 1'b1;
    ld_resp_mshrid_i = tag;
    ld_resp_data_i   = d;
    @(posedge clk); #1;
    ld_resp_valid_i  = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int budget = 0;
    while (exp_trans.size() != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    checkOutput(name, 64'(exp_trans.size()), 64'd0);
  endtask

  task automatic do_reset(input logic [31:0] len);
    @(posedge clk); #2;
    rst_n = 1'b0;
    addr_valid_i = 1'b0;
    ld_resp_valid_i = 1'b0;
    #1;
    checkOutput("rst_addr_ready", 64'(addr_ready_o), 64'd1);
    checkOutput("rst_ld_req_valid", 64'(ld_req_valid_o), 64'd0);
    checkOutput("rst_ld_req_addr", ld_req_addr_o, 64'd0);
    checkOutput("rst_ld_req_mshrid", 64'(ld_req_mshrid_o), 64'd0);
    checkOutput("rst_trans_valid", 64'(trans_valid_o), 64'd0);
    checkOutput("rst_trans_ckpt", 64'(trans_ckpt_o), 64'd0);
    checkOutput("rst_trans_data", trans_data_o, 64'd0);
    checkOutput("rst_trans_addr", trans_addr_o, 64'd0);
    checkOutput("rst_tail_ptr", 64'(tail_ptr_o), 64'd0);
    exp_req.delete();
    exp_trans.delete();
    alloc_cnt = 0;
    fifo_length_i = len;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Request and transaction monitors plus the tail-pointer model.
  always @(negedge clk) begin
    if (!rst_n) begin
      tail_m = '0;
    end else begin
      checkOutput("tail_ptr", 64'(tail_ptr_o), 64'(tail_m));
      if (ld_req_valid_o && ld_req_ready_i) begin
        if (exp_req.size() == 0) report_fail("unexpected_req");
        else begin
          mon_r = exp_req.pop_front();
          checkOutput("req_addr", ld_req_addr_o, mon_r.addr);
          checkOutput("req_size", 64'(ld_req_size_o), 64'(mon_r.size));
          checkOutput("req_mshrid", 64'(ld_req_mshrid_o), 64'(mon_r.tag));
        end
      end
      if (trans_valid_o && trans_ready_i) begin
        if (exp_trans.size() == 0) report_fail("unexpected_trans");
        else begin
          mon_t = exp_trans.pop_front();
          checkOutput("trans_data", trans_data_o, mon_t.data);
          checkOutput("trans_addr", trans_addr_o, mon_t.addr);
          checkOutput("trans_ckpt", 64'(trans_ckpt_o), 64'(mon_t.ckpt));
        end
        if (!trans_ckpt_o)
          tail_m = (tail_m == fifo_length_i - 32'd1) ? 32'd0 : tail_m + 32'd1;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    addr_valid_i = 1'b0; addr_i = '0; size_i = '0;
    fifo_length_i = 32'd100;
    ld_req_ready_i = 1'b0; trans_ready_i = 1'b0;
    ld_resp_valid_i = 1'b0; ld_resp_mshrid_i = '0; ld_resp_data_i = '0;
    tail_ptr_addr_i = TAIL_ADDR;

    // Single load with minimum latency.
    do_reset(32'd100);
    ld_req_ready_i = 1'b1; trans_ready_i = 1'b1;
    expect_trans(64'hA5, 64'h1000, 1'b0);
    applyStimulus(64'h1000, 32'd8);
    @(posedge clk); #1;
    ld_resp_valid_i = 1'b1; ld_resp_mshrid_i = 8'd144; ld_resp_data_i = 64'hA5;
    @(negedge clk);
    checkOutput("lat_not_early", 64'(trans_valid_o), 64'd0);
    @(posedge clk); #1;
    ld_resp_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("lat_valid_t2", 64'(trans_valid_o), 64'd1);
    drain("drain_single");
    checkOutput("single_tail", 64'(tail_ptr_o), 64'd1);

    // Out-of-order responses still commit in allocation order.
    do_reset(32'd100);
    ld_req_ready_i = 1'b1; trans_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_trans(64'h20 + 64'(i), 64'h2000 + 64'(i * 16), 1'b0);
      applyStimulus(64'h2000 + 64'(i * 16), 32'd4);
    end
    expect_trans(64'd4, TAIL_ADDR, 1'b1);
    wait_cycles(3);
    respond(8'd147, 64'h23);
    respond(8'd145, 64'h21);
    respond(8'd146, 64'h22);
    @(negedge clk);
    checkOutput("ooo_head_blocks", 64'(trans_valid_o), 64'd0);
    @(posedge clk); #1;
    respond(8'd144, 64'h20);
    drain("drain_ooo");
    checkOutput("ooo_tail", 64'(tail_ptr_o), 64'd4);

    // Full pool: ready stays low until the head commits.
    do_reset(32'd100);
    ld_req_ready_i = 1'b1; trans_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_trans(64'h30 + 64'(i), 64'h3000 + 64'(i * 8), 1'b0);
      applyStimulus(64'h3000 + 64'(i * 8), 32'd8);
    end
    expect_trans(64'd4, TAIL_ADDR, 1'b1);
    wait_cycles(3);
    for (int i = 0; i < 4; i++) respond(BASE + 8'(i), 64'h30 + 64'(i));
    addr_valid_i = 1'b1; addr_i = 64'h3100; size_i = 32'd4;
    repeat (3) begin
      @(negedge clk);
      checkOutput("full_not_ready", 64'(addr_ready_o), 64'd0);
    end
    @(posedge clk); #1;
    trans_ready_i = 1'b1;
    @(negedge clk);
    checkOutput("full_before_commit", 64'(addr_ready_o), 64'd0);
    @(negedge clk);
    checkOutput("full_freed_next", 64'(addr_ready_o), 64'd1);
    push_req(64'h3100, 32'd4);
    expect_trans(64'h99, 64'h3100, 1'b0);
    @(posedge clk); #1;
    addr_valid_i = 1'b0;
    wait_cycles(2);
    respond(8'd144, 64'h99);
    drain("drain_full");
    checkOutput("full_tail", 64'(tail_ptr_o), 64'd5);

    // Checkpoint after the fourth data transaction, tail wraps at length 3.
    do_reset(32'd3);
    ld_req_ready_i = 1'b1; trans_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_trans(64'h50 + 64'(i), 64'h5000 + 64'(i * 8), 1'b0);
      applyStimulus(64'h5000 + 64'(i * 8), 32'd2);
    end
    expect_trans(64'd1, TAIL_ADDR, 1'b1);
    wait_cycles(3);
    for (int i = 0; i < 4; i++) respond(BASE + 8'(i), 64'h50 + 64'(i));
    drain("drain_ckpt");
    checkOutput("ckpt_tail", 64'(tail_ptr_o), 64'd1);

    // Backpressure, unmatched tag noise, then reset mid-flight.
    do_reset(32'd100);
    ld_req_ready_i = 1'b0; trans_ready_i = 1'b0;
    applyStimulus(64'h4000, 32'd8);
    applyStimulus(64'h4008, 32'd8);
    respond(8'd200, 64'hDEAD);
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_req_valid", 64'(ld_req_valid_o), 64'd1);
      checkOutput("bp_req_addr", ld_req_addr_o, 64'h4000);
      checkOutput("bp_req_mshrid", 64'(ld_req_mshrid_o), 64'd144);
    end
    @(posedge clk); #1;
    ld_req_ready_i = 1'b1;
    wait_cycles(2);
    ld_req_ready_i = 1'b0;
    expect_trans(64'h61, 64'h4000, 1'b0);
    respond(8'd144, 64'h61);
    respond(8'd200, 64'hBAD);
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_trans_valid", 64'(trans_valid_o), 64'd1);
      checkOutput("bp_trans_data", trans_data_o, 64'h61);
      checkOutput("bp_trans_addr", trans_addr_o, 64'h4000);
    end
    @(posedge clk); #1;
    trans_ready_i = 1'b1;
    @(posedge clk); #1;
    trans_ready_i = 1'b0;
    @(negedge clk);
    checkOutput("unmatched_dropped", 64'(trans_valid_o), 64'd0);
    checkOutput("bp_queue_empty", 64'(exp_trans.size()), 64'd0);
    respond(8'd145, 64'h62);
    applyStimulus(64'h4010, 32'd8);
    @(negedge clk);
    checkOutput("pre_rst_trans_valid", 64'(trans_valid_o), 64'd1);
    checkOutput("pre_rst_req_valid", 64'(ld_req_valid_o), 64'd1);
    do_reset(32'd100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
